// File: rtl/ms_arb_pkg.sv
// Shared types and helpers for the memory data-bus arbiter and its picker.
package ms_arb_pkg;

  localparam int unsigned CSizeW = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACK
  } arb_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ms_rr_pick.sv
// Combinational requester picker: lowest-index priority requester first,
// otherwise round-robin starting at start_i. Excluded requesters never win.
module ms_rr_pick
  import ms_arb_pkg::*;
#(
  parameter int unsigned CReqCnt = 3
) (
  input  logic [CReqCnt-1:0]        active_i,
  input  logic [CReqCnt-1:0]        excl_i,
  input  logic [CReqCnt-1:0]        prio_i,
  input  logic [idx_w(CReqCnt)-1:0] start_i,
  output logic                      found_o,
  output logic [idx_w(CReqCnt)-1:0] idx_o
);

  localparam int unsigned IdxW = idx_w(CReqCnt);

  logic [CReqCnt-1:0] elig;
  logic               prio_found;
  logic [IdxW-1:0]    prio_idx;
  logic               rr_found;
  logic [IdxW-1:0]    rr_idx;
  logic [IdxW-1:0]    cand;

  assign elig = active_i & ~excl_i;

  always_comb begin
    prio_found = 1'b0;
    prio_idx   = '0;
    rr_found   = 1'b0;
    rr_idx     = '0;
    cand       = '0;
    for (int unsigned i = 0; i < CReqCnt; i++) begin
      if (!prio_found && elig[i] && prio_i[i]) begin
        prio_found = 1'b1;
        prio_idx   = IdxW'(i);
      end
    end
    for (int unsigned k = 0; k < CReqCnt; k++) begin
      cand = IdxW'((32'(start_i) + k) % CReqCnt);
      if (!rr_found && elig[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign found_o = prio_found | rr_found;
  assign idx_o   = prio_found ? prio_idx : rr_idx;

endmodule

// File: rtl/ms_data_arb.sv
// N-requester data-bus arbiter in front of the single memory data port, with
// priority class, bounded bus locking and a busy-timeout abort.
module ms_data_arb
  import ms_arb_pkg::*;
#(
  parameter int unsigned         CReqCnt   = 3,
  parameter int unsigned         CAddrW    = 32,
  parameter int unsigned         CDataW    = 64,
  parameter logic [CReqCnt-1:0]  CPrioMask = '0,
  parameter int unsigned         CLockMax  = 4,
  parameter int unsigned         CTimeout  = 255
) (
  input  logic                        AClkH,
  input  logic                        AResetHN,
  input  logic                        AClkHEn,
  input  logic [CReqCnt*CAddrW-1:0]   AReqAddr,
  input  logic [CReqCnt*CDataW-1:0]   AReqMosi,
  input  logic [CReqCnt*CSizeW-1:0]   AReqWrSize,
  input  logic [CReqCnt*CSizeW-1:0]   AReqRdSize,
  input  logic [CReqCnt-1:0]          AReqLock,
  output logic [CReqCnt-1:0]          AReqAck,
  output logic [CDataW-1:0]           AReqMiso,
  output logic [CAddrW-1:0]           AMemAddr,
  output logic [CDataW-1:0]           AMemMosi,
  output logic [CSizeW-1:0]           AMemWrSize,
  output logic [CSizeW-1:0]           AMemRdSize,
  input  logic [CDataW-1:0]           AMemMiso,
  input  logic                        AMemBusy,
  output logic [idx_w(CReqCnt)-1:0]   AGrantIdx,
  output logic                        ATimeout
);

  localparam int unsigned IdxW  = idx_w(CReqCnt);
  localparam int unsigned LockW = $clog2(CLockMax + 1);
  localparam int unsigned TmoW  = $clog2(CTimeout + 1);

  logic [CAddrW-1:0] addr_a [CReqCnt];
  logic [CDataW-1:0] mosi_a [CReqCnt];
  logic [CSizeW-1:0] wr_a   [CReqCnt];
  logic [CSizeW-1:0] rd_a   [CReqCnt];
  logic [CReqCnt-1:0] active;

  for (genvar g = 0; g < CReqCnt; g++) begin : g_unpack
    assign addr_a[g] = AReqAddr[g*CAddrW +: CAddrW];
    assign mosi_a[g] = AReqMosi[g*CDataW +: CDataW];
    assign wr_a[g]   = AReqWrSize[g*CSizeW +: CSizeW];
    assign rd_a[g]   = AReqRdSize[g*CSizeW +: CSizeW];
    assign active[g] = (wr_a[g] != '0) || (rd_a[g] != '0);
  end

  arb_state_e         state_q, state_d;
  logic [IdxW-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]    rr_q, rr_d;
  logic [LockW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic               lock_hold_q, lock_hold_d;
  logic [CReqCnt-1:0] ack_q, ack_d;
  logic [CDataW-1:0]  miso_q, miso_d;
  logic               tout_q, tout_d;

  logic [IdxW-1:0]    rr_next;
  logic [IdxW-1:0]    pick_start;
  logic [CReqCnt-1:0] pick_excl;
  logic               pick_found;
  logic [IdxW-1:0]    pick_idx;
  logic               cur_is_wr;
  logic               lock_keep;

  assign rr_next    = (grant_q == IdxW'(CReqCnt - 1)) ? '0 : grant_q + 1'b1;
  assign cur_is_wr  = (wr_a[grant_q] != '0);
  assign lock_keep  = lock_hold_q && (lock_cnt_q < LockW'(CLockMax - 1));

  // In ACK the finished requester still shows its request, so it is masked
  // out and the search starts just past it.
  always_comb begin
    pick_excl  = '0;
    pick_start = rr_q;
    if (state_q == ST_ACK) begin
      pick_excl[grant_q] = 1'b1;
      pick_start         = rr_next;
    end
  end

  ms_rr_pick #(
    .CReqCnt(CReqCnt)
  ) u_pick (
    .active_i (active),
    .excl_i   (pick_excl),
    .prio_i   (CPrioMask),
    .start_i  (pick_start),
    .found_o  (pick_found),
    .idx_o    (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    lock_cnt_d  = lock_cnt_q;
    tmo_d       = tmo_q;
    lock_hold_d = lock_hold_q;
    ack_d       = ack_q;
    miso_d      = miso_q;
    tout_d      = tout_q;
    if (AClkHEn) begin
      unique case (state_q)
        ST_IDLE: begin
          ack_d  = '0;
          miso_d = '0;
          tout_d = 1'b0;
          if (pick_found) begin
            grant_d = pick_idx;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!AMemBusy) begin
            miso_d          = cur_is_wr ? '0 : AMemMiso;
            ack_d           = '0;
            ack_d[grant_q]  = 1'b1;
            lock_hold_d     = AReqLock[grant_q];
            tmo_d           = '0;
            state_d         = ST_ACK;
          end else if (tmo_q == TmoW'(CTimeout - 1)) begin
            miso_d          = '0;
            ack_d           = '0;
            ack_d[grant_q]  = 1'b1;
            lock_hold_d     = 1'b0;
            tout_d          = 1'b1;
            tmo_d           = '0;
            state_d         = ST_ACK;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ST_ACK: begin
          ack_d  = '0;
          miso_d = '0;
          tout_d = 1'b0;
          if (lock_keep) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
            state_d    = ST_ISSUE;
          end else begin
            rr_d       = rr_next;
            lock_cnt_d = '0;
            tmo_d      = '0;
            if (pick_found) begin
              grant_d = pick_idx;
              state_d = ST_ISSUE;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      lock_cnt_q  <= '0;
      tmo_q       <= '0;
      lock_hold_q <= 1'b0;
      ack_q       <= '0;
      miso_q      <= '0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      lock_cnt_q  <= lock_cnt_d;
      tmo_q       <= tmo_d;
      lock_hold_q <= lock_hold_d;
      ack_q       <= ack_d;
      miso_q      <= miso_d;
      tout_q      <= tout_d;
    end
  end

  always_comb begin
    AMemAddr   = '0;
    AMemMosi   = '0;
    AMemWrSize = '0;
    AMemRdSize = '0;
    if (state_q == ST_ISSUE) begin
      AMemAddr   = addr_a[grant_q];
      AMemMosi   = mosi_a[grant_q];
      AMemWrSize = wr_a[grant_q];
      AMemRdSize = cur_is_wr ? '0 : rd_a[grant_q];
    end
  end

  assign AReqAck   = ack_q;
  assign AReqMiso  = miso_q;
  assign AGrantIdx = grant_q;
  assign ATimeout  = tout_q;

endmodule

// File: tb/tb_ms_data_arb.sv
// Directed bench for ms_data_arb: expected acks are queued when requests are
// driven and checked by a monitor as the arbiter produces them.
module tb_ms_data_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [95:0]  req_addr;
  logic [191:0] req_mosi;
  logic [11:0]  req_wr;
  logic [11:0]  req_rd;
  logic [2:0]   req_lock;
  logic [63:0]  mem_miso;
  logic         mem_busy;

  logic [2:0]   a_ack,  b_ack;
  logic [63:0]  a_miso, b_miso;
  logic [31:0]  a_addr, b_addr;
  logic [63:0]  a_mosi, b_mosi;
  logic [3:0]   a_wr,   b_wr;
  logic [3:0]   a_rd,   b_rd;
  logic [1:0]   a_gnt,  b_gnt;
  logic         a_tout, b_tout;

  int total = 0;
  int bad   = 0;
  logic mon_sel = 1'b0;

  typedef struct {
    int          idx;
    logic [63:0] miso;
    logic        tout;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ms_data_arb #(
    .CReqCnt(3), .CAddrW(32), .CDataW(64), .CPrioMask(3'b000),
    .CLockMax(4), .CTimeout(10)
  ) u_dut (
    .AClkH(clk), .AResetHN(rst_n), .AClkHEn(en),
    .AReqAddr(req_addr), .AReqMosi(req_mosi), .AReqWrSize(req_wr),
    .AReqRdSize(req_rd), .AReqLock(req_lock), .AReqAck(a_ack),
    .AReqMiso(a_miso), .AMemAddr(a_addr), .AMemMosi(a_mosi),
    .AMemWrSize(a_wr), .AMemRdSize(a_rd), .AMemMiso(mem_miso),
    .AMemBusy(mem_busy), .AGrantIdx(a_gnt), .ATimeout(a_tout)
  );

  ms_data_arb #(
    .CReqCnt(3), .CAddrW(32), .CDataW(64), .CPrioMask(3'b100),
    .CLockMax(4), .CTimeout(10)
  ) u_dut_prio (
    .AClkH(clk), .AResetHN(rst_n), .AClkHEn(en),
    .AReqAddr(req_addr), .AReqMosi(req_mosi), .AReqWrSize(req_wr),
    .AReqRdSize(req_rd), .AReqLock(req_lock), .AReqAck(b_ack),
    .AReqMiso(b_miso), .AMemAddr(b_addr), .AMemMosi(b_mosi),
    .AMemWrSize(b_wr), .AMemRdSize(b_rd), .AMemMiso(mem_miso),
    .AMemBusy(mem_busy), .AGrantIdx(b_gnt), .ATimeout(b_tout)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int idx, input logic [63:0] miso, input logic tout);
    exp_t e;
    e.idx  = idx;
    e.miso = miso;
    e.tout = tout;
    sb_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [63:0] d,
                         input logic [3:0] w, input logic [3:0] r);
    req_addr[i*32 +: 32] = a;
    req_mosi[i*64 +: 64] = d;
    req_wr[i*4 +: 4]     = w;
    req_rd[i*4 +: 4]     = r;
  endtask

  task automatic clr_req(input int i);
    set_req(i, '0, '0, '0, '0);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    en       = 1'b1;
    req_addr = '0;
    req_mosi = '0;
    req_wr   = '0;
    req_rd   = '0;
    req_lock = '0;
    mem_miso = '0;
    mem_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain", sb_q.size(), 0);
  endtask

  // Ack monitor for whichever instance is under test.
  logic [2:0]  mon_ack;
  logic [63:0] mon_miso;
  logic        mon_tout;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon_ack  = mon_sel ? b_ack  : a_ack;
      mon_miso = mon_sel ? b_miso : a_miso;
      mon_tout = mon_sel ? b_tout : a_tout;
      if (mon_ack != 3'b000) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", mon_ack, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("ack_vec", mon_ack, 64'(3'b001 << mon_e.idx));
          chk("ack_miso", mon_miso, mon_e.miso);
          chk("ack_tout", mon_tout, mon_e.tout);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    req_addr = '0;
    req_mosi = '0;
    req_wr   = '0;
    req_rd   = '0;
    req_lock = '0;
    mem_miso = '0;
    mem_busy = 1'b0;
    set_req(0, 32'h10, 64'h1, 4'd2, 4'd0);
    @(negedge clk);
    chk("rst_ack", a_ack, 0);
    chk("rst_miso", a_miso, 0);
    chk("rst_wr", a_wr, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_gnt", a_gnt, 0);
    chk("rst_tout", a_tout, 0);

    // single read from requester 1
    do_reset();
    mon_sel = 1'b0;
    set_req(1, 32'h100, 64'h0, 4'd0, 4'd8);
    mem_miso = 64'hDEAD;
    push(1, 64'hDEAD, 1'b0);
    nxt();
    chk("rd_issue_rd", a_rd, 8);
    chk("rd_issue_addr", a_addr, 32'h100);
    chk("rd_issue_gnt", a_gnt, 1);
    chk("rd_issue_wr", a_wr, 0);
    nxt();
    chk("rd_ack_rdsize", a_rd, 0);
    clr_req(1);
    nxt();
    chk("rd_idle_rd", a_rd, 0);
    chk("rd_idle_gnt", a_gnt, 1);
    drain();

    // round robin, continuous writes; requester 2 also shows a read size
    do_reset();
    mem_miso = 64'h1234;
    for (int i = 0; i < 3; i++)
      set_req(i, 32'h1000 + 32'(i * 16), 64'hC0DE_0000 + 64'(i), 4'd4, (i == 2) ? 4'd6 : 4'd0);
    for (int k = 0; k < 6; k++) push(k % 3, 64'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      nxt();
      chk("rr_gnt", a_gnt, 64'(k % 3));
      chk("rr_addr", a_addr, 32'h1000 + 32'((k % 3) * 16));
      chk("rr_mosi", a_mosi, 64'hC0DE_0000 + 64'(k % 3));
      chk("rr_wr", a_wr, 4);
      chk("rr_rd", a_rd, 0);
      nxt();
      chk("rr_ack_wr", a_wr, 0);
    end
    req_wr = '0;
    req_rd = '0;
    drain();

    // priority: requester 2 wins over 0
    do_reset();
    mon_sel = 1'b1;
    mem_miso = 64'hA5;
    set_req(0, 32'h200, 64'h0, 4'd0, 4'd2);
    set_req(2, 32'h220, 64'h0, 4'd0, 4'd2);
    push(2, 64'hA5, 1'b0);
    push(0, 64'hA5, 1'b0);
    nxt();
    chk("prio_first_gnt", b_gnt, 2);
    chk("prio_first_addr", b_addr, 32'h220);
    nxt();
    clr_req(2);
    nxt();
    chk("prio_second_gnt", b_gnt, 0);
    chk("prio_second_addr", b_addr, 32'h200);
    nxt();
    clr_req(0);
    drain();
    mon_sel = 1'b0;

    // lock: requester 0 holds the bus for CLockMax transactions
    do_reset();
    mem_miso = 64'h77;
    set_req(0, 32'h400, 64'h0, 4'd0, 4'd1);
    set_req(1, 32'h500, 64'h0, 4'd0, 4'd1);
    req_lock = 3'b001;
    for (int k = 0; k < 4; k++) push(0, 64'h77, 1'b0);
    push(1, 64'h77, 1'b0);
    for (int t = 0; t < 4; t++) begin
      nxt();
      chk("lock_gnt", a_gnt, 0);
      chk("lock_addr", a_addr, 32'h400);
      nxt();
      chk("lock_ack_rd", a_rd, 0);
    end
    clr_req(0);
    req_lock = 3'b000;
    nxt();
    chk("lock_release_gnt", a_gnt, 1);
    chk("lock_release_addr", a_addr, 32'h500);
    nxt();
    clr_req(1);
    drain();

    // busy timeout after 10 busy cycles
    do_reset();
    mem_miso = 64'hBEEF;
    mem_busy = 1'b1;
    set_req(2, 32'h600, 64'h42, 4'd8, 4'd0);
    push(2, 64'h0, 1'b1);
    nxt();
    chk("tmo_gnt", a_gnt, 2);
    chk("tmo_wr", a_wr, 8);
    for (int k = 2; k <= 10; k++) begin
      nxt();
      chk("tmo_wait_tout", a_tout, 0);
      chk("tmo_wait_wr", a_wr, 8);
    end
    nxt();
    chk("tmo_pulse", a_tout, 1);
    chk("tmo_ack_wr", a_wr, 0);
    clr_req(2);
    mem_busy = 1'b0;
    nxt();
    chk("tmo_pulse_end", a_tout, 0);
    chk("tmo_idle_wr", a_wr, 0);
    drain();

    // clock enable low for 5 cycles during ISSUE
    do_reset();
    mem_miso = 64'h55;
    set_req(0, 32'h700, 64'h0, 4'd0, 4'd3);
    nxt();
    chk("en_issue_rd", a_rd, 3);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      nxt();
      chk("en_hold_rd", a_rd, 3);
      chk("en_hold_addr", a_addr, 32'h700);
      chk("en_hold_ack", a_ack, 0);
    end
    en = 1'b1;
    push(0, 64'h55, 1'b0);
    nxt();
    clr_req(0);
    drain();

    // asynchronous reset in the middle of ISSUE
    do_reset();
    mem_busy = 1'b1;
    set_req(1, 32'h300, 64'h99, 4'd5, 4'd0);
    nxt();
    chk("arst_pre_wr", a_wr, 5);
    chk("arst_pre_gnt", a_gnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr", a_wr, 0);
    chk("arst_addr", a_addr, 0);
    chk("arst_mosi", a_mosi, 0);
    chk("arst_gnt", a_gnt, 0);
    chk("arst_ack", a_ack, 0);
    chk("arst_tout", a_tout, 0);
    @(negedge clk);
    clr_req(1);
    mem_busy = 1'b0;
    rst_n = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
